// File: rtl/axi_err_slv.sv
// AXI4 error responder for unmapped crossbar ports: every write is answered
// with one B beat and every read with len+1 R beats, all carrying RESP.
module axi_err_slv #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned USER_WIDTH = 1,
    parameter logic [1:0]  RESP       = 2'b11,
    parameter logic [63:0] RESP_DATA  = 64'hCA11AB1E
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // AW
    input  logic [ID_WIDTH-1:0]     slv_aw_id,
    input  logic [ADDR_WIDTH-1:0]   slv_aw_addr,
    input  logic [7:0]              slv_aw_len,
    input  logic [2:0]              slv_aw_size,
    input  logic [1:0]              slv_aw_burst,
    input  logic                    slv_aw_lock,
    input  logic [3:0]              slv_aw_cache,
    input  logic [2:0]              slv_aw_prot,
    input  logic [3:0]              slv_aw_qos,
    input  logic [3:0]              slv_aw_region,
    input  logic [5:0]              slv_aw_atop,
    input  logic [USER_WIDTH-1:0]   slv_aw_user,
    input  logic                    slv_aw_valid,
    output logic                    slv_aw_ready,
    // W
    input  logic [DATA_WIDTH-1:0]   slv_w_data,
    input  logic [DATA_WIDTH/8-1:0] slv_w_strb,
    input  logic                    slv_w_last,
    input  logic [USER_WIDTH-1:0]   slv_w_user,
    input  logic                    slv_w_valid,
    output logic                    slv_w_ready,
    // B
    output logic [ID_WIDTH-1:0]     slv_b_id,
    output logic [1:0]              slv_b_resp,
    output logic [USER_WIDTH-1:0]   slv_b_user,
    output logic                    slv_b_valid,
    input  logic                    slv_b_ready,
    // AR
    input  logic [ID_WIDTH-1:0]     slv_ar_id,
    input  logic [ADDR_WIDTH-1:0]   slv_ar_addr,
    input  logic [7:0]              slv_ar_len,
    input  logic [2:0]              slv_ar_size,
    input  logic [1:0]              slv_ar_burst,
    input  logic                    slv_ar_lock,
    input  logic [3:0]              slv_ar_cache,
    input  logic [2:0]              slv_ar_prot,
    input  logic [3:0]              slv_ar_qos,
    input  logic [3:0]              slv_ar_region,
    input  logic [USER_WIDTH-1:0]   slv_ar_user,
    input  logic                    slv_ar_valid,
    output logic                    slv_ar_ready,
    // R
    output logic [ID_WIDTH-1:0]     slv_r_id,
    output logic [DATA_WIDTH-1:0]   slv_r_data,
    output logic [1:0]              slv_r_resp,
    output logic                    slv_r_last,
    output logic [USER_WIDTH-1:0]   slv_r_user,
    output logic                    slv_r_valid,
    input  logic                    slv_r_ready,
    output logic                    idle_o
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

    localparam logic [DATA_WIDTH-1:0] RDATA = DATA_WIDTH'(RESP_DATA);

    wr_state_e             wr_state_r, wr_state_s;
    rd_state_e             rd_state_r, rd_state_s;
    logic [ID_WIDTH-1:0]   aw_id_r;
    logic [ID_WIDTH-1:0]   ar_id_r;
    logic [7:0]            ar_len_r;
    logic [7:0]            cnt_r;
    logic                  r_last_s;

    // Payload and sideband fields carry no meaning for an error responder.
    logic unused_s;
    assign unused_s = ^{slv_aw_addr, slv_aw_len, slv_aw_size, slv_aw_burst, slv_aw_lock,
                        slv_aw_cache, slv_aw_prot, slv_aw_qos, slv_aw_region, slv_aw_atop,
                        slv_aw_user, slv_w_data, slv_w_strb, slv_w_user, slv_ar_addr,
                        slv_ar_size, slv_ar_burst, slv_ar_lock, slv_ar_cache, slv_ar_prot,
                        slv_ar_qos, slv_ar_region, slv_ar_user};

    assign r_last_s = (cnt_r == ar_len_r);

    // Write FSM next-state decode
    always_comb begin
        wr_state_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (slv_aw_valid) wr_state_s = W_DATA;
                else              wr_state_s = W_IDLE;
            end
            W_DATA: begin
                if (slv_w_valid && slv_w_last) wr_state_s = W_RESP;
                else                           wr_state_s = W_DATA;
            end
            W_RESP: begin
                if (slv_b_ready) wr_state_s = W_IDLE;
                else             wr_state_s = W_RESP;
            end
            default: wr_state_s = W_IDLE;
        endcase
    end

    // Read FSM next-state decode; leaves RDATA only on the last beat handshake
    always_comb begin
        rd_state_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (slv_ar_valid) rd_state_s = R_DATA;
                else              rd_state_s = R_IDLE;
            end
            R_DATA: begin
                if (slv_r_ready && r_last_s) rd_state_s = R_IDLE;
                else                         rd_state_s = R_DATA;
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // Write state and latched AW id
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_state_r <= W_IDLE;
            aw_id_r    <= {ID_WIDTH{1'b0}};
        end else begin
            wr_state_r <= wr_state_s;
            if (wr_state_r == W_IDLE && slv_aw_valid) aw_id_r <= slv_aw_id;
            else                                     aw_id_r <= aw_id_r;
        end
    end

    // Read state, latched AR id/len and beat counter (held at len on the last beat)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_r <= R_IDLE;
            ar_id_r    <= {ID_WIDTH{1'b0}};
            ar_len_r   <= 8'd0;
            cnt_r      <= 8'd0;
        end else begin
            rd_state_r <= rd_state_s;
            if (rd_state_r == R_IDLE && slv_ar_valid) begin
                ar_id_r  <= slv_ar_id;
                ar_len_r <= slv_ar_len;
                cnt_r    <= 8'd0;
            end else if (rd_state_r == R_DATA && slv_r_ready && !r_last_s) begin
                cnt_r    <= cnt_r + 8'd1;
            end else begin
                cnt_r    <= cnt_r;
            end
        end
    end

    assign slv_aw_ready = (wr_state_r == W_IDLE);
    assign slv_w_ready  = (wr_state_r == W_DATA);
    assign slv_b_valid  = (wr_state_r == W_RESP);
    assign slv_b_id     = aw_id_r;
    assign slv_b_resp   = RESP;
    assign slv_b_user   = {USER_WIDTH{1'b0}};

    assign slv_ar_ready = (rd_state_r == R_IDLE);
    assign slv_r_valid  = (rd_state_r == R_DATA);
    assign slv_r_id     = ar_id_r;
    assign slv_r_data   = RDATA;
    assign slv_r_resp   = RESP;
    assign slv_r_last   = r_last_s;
    assign slv_r_user   = {USER_WIDTH{1'b0}};

    assign idle_o = (wr_state_r == W_IDLE) && (rd_state_r == R_IDLE);

endmodule

// File: tb/tb_axi_err_slv.sv
// Randomized directed bench for axi_err_slv: a cycle-level transaction model
// predicts every handshake, beat count and response field.
module tb_axi_err_slv;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int UW = 2;
    localparam logic [63:0] EXP_RDATA = 64'h0000_0000_CA11_AB1E;
    localparam logic [63:0] EXP_RESP  = 64'd3;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] aw_id = '0, ar_id = '0, b_id, r_id;
    logic [7:0]    aw_len = '0, ar_len = '0;
    logic [5:0]    aw_atop = '0;
    logic          aw_valid = 1'b0, aw_ready, ar_valid = 1'b0, ar_ready;
    logic [DW-1:0] w_data = '0, r_data;
    logic          w_last = 1'b0, w_valid = 1'b0, w_ready;
    logic [1:0]    b_resp, r_resp;
    logic [UW-1:0] b_user, r_user;
    logic          b_valid, b_ready = 1'b0;
    logic          r_last, r_valid, r_ready = 1'b0, idle;

    axi_err_slv #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .slv_aw_id(aw_id), .slv_aw_addr(32'h1000_0000), .slv_aw_len(aw_len), .slv_aw_size(3'd2),
        .slv_aw_burst(2'b01), .slv_aw_lock(1'b0), .slv_aw_cache(4'd0), .slv_aw_prot(3'd0),
        .slv_aw_qos(4'd0), .slv_aw_region(4'd0), .slv_aw_atop(aw_atop), .slv_aw_user(2'b11),
        .slv_aw_valid(aw_valid), .slv_aw_ready(aw_ready),
        .slv_w_data(w_data), .slv_w_strb(4'hF), .slv_w_last(w_last), .slv_w_user(2'b10),
        .slv_w_valid(w_valid), .slv_w_ready(w_ready),
        .slv_b_id(b_id), .slv_b_resp(b_resp), .slv_b_user(b_user), .slv_b_valid(b_valid),
        .slv_b_ready(b_ready),
        .slv_ar_id(ar_id), .slv_ar_addr(32'h2000_0000), .slv_ar_len(ar_len), .slv_ar_size(3'd2),
        .slv_ar_burst(2'b01), .slv_ar_lock(1'b0), .slv_ar_cache(4'd0), .slv_ar_prot(3'd0),
        .slv_ar_qos(4'd0), .slv_ar_region(4'd0), .slv_ar_user(2'b01),
        .slv_ar_valid(ar_valid), .slv_ar_ready(ar_ready),
        .slv_r_id(r_id), .slv_r_data(r_data), .slv_r_resp(r_resp), .slv_r_last(r_last),
        .slv_r_user(r_user), .slv_r_valid(r_valid), .slv_r_ready(r_ready),
        .idle_o(idle)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model phases: write 0=data 1=resp 2=done; read 0=data 2=done.
    // rmode: 0 always ready, 1 toggle starting low, 2 random. abort_at<0: run to end.
    task automatic txn(input bit do_w, input logic [IW-1:0] wid, input int wbeats,
                       input bit do_r, input logic [IW-1:0] rid, input logic [7:0] rlen,
                       input int rmode, input int wgap_pct, input int bdelay, input int abort_at);
        int wph, rph, wsent, bcnt, rbeat, nwph, nrph;
        bit done, aborted, wv, rr;
        done = 1'b0; aborted = 1'b0;
        wsent = 0; bcnt = 0; rbeat = 0;
        chk("accept_idle", idle, 1);
        chk("accept_aw_ready", aw_ready, 1);
        chk("accept_ar_ready", ar_ready, 1);
        aw_valid = do_w; aw_id = wid; aw_len = 8'(wbeats - 1); aw_atop = 6'($urandom_range(0, 63));
        ar_valid = do_r; ar_id = rid; ar_len = rlen;
        @(negedge clk);
        aw_valid = 1'b0; ar_valid = 1'b0;
        aw_id = 4'($urandom); ar_id = 4'($urandom);
        wph = do_w ? 0 : 2;
        rph = do_r ? 0 : 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("idle_o", idle, (wph == 2 && rph == 2));
            chk("w_ready", w_ready, (wph == 0));
            chk("b_valid", b_valid, (wph == 1));
            chk("aw_ready", aw_ready, (wph == 2));
            if (wph == 1) begin
                chk("b_id", b_id, wid);
                chk("b_resp", b_resp, EXP_RESP);
                chk("b_user", b_user, 0);
            end
            chk("r_valid", r_valid, (rph == 0));
            chk("ar_ready", ar_ready, (rph == 2));
            if (rph == 0) begin
                chk("r_id", r_id, rid);
                chk("r_data", r_data, EXP_RDATA);
                chk("r_resp", r_resp, EXP_RESP);
                chk("r_last", r_last, (rbeat == int'(rlen)));
                chk("r_user", r_user, 0);
            end
            if (wph == 2 && rph == 2) begin
                done = 1'b1;
                break;
            end
            if (cyc == abort_at) begin
                aborted = 1'b1;
                break;
            end
            nwph = wph; nrph = rph;
            wv = 1'b0; rr = 1'b0;
            if (wph == 0) begin
                wv = ($urandom_range(0, 99) >= wgap_pct);
                w_valid = wv; w_data = $urandom;
                w_last = (wsent == wbeats - 1);
                if (wv) begin
                    if (wsent == wbeats - 1) nwph = 1;
                    wsent++;
                end
                b_ready = 1'b0;
            end else if (wph == 1) begin
                w_valid = 1'b0; w_last = 1'b0;
                b_ready = (bcnt >= bdelay);
                if (bcnt >= bdelay) nwph = 2;
                bcnt++;
            end else begin
                w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
            end
            if (rph == 0) begin
                case (rmode)
                    0: rr = 1'b1;
                    1: rr = (cyc % 2 == 1);
                    default: rr = $urandom_range(0, 1) == 1;
                endcase
                if (rr) begin
                    if (rbeat == int'(rlen)) nrph = 2;
                    rbeat++;
                end
            end
            r_ready = rr;
            @(negedge clk);
            wph = nwph; rph = nrph;
        end
        total++;
        assert (done || aborted) else begin
            bad++;
            $error("FAIL timeout observed=%0d expected=1", done);
        end
        if (done) begin
            chk("w_beats", wsent, do_w ? wbeats : 0);
            chk("r_beats", rbeat, do_r ? int'(rlen) + 1 : 0);
        end
        w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
    endtask

    initial begin
        // 1: outputs while in reset
        #12;
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_idle", idle, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        // W before AW must not be accepted
        w_valid = 1'b1; w_last = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("early_w_ready", w_ready, 0);
            chk("early_b_valid", b_valid, 0);
        end
        w_valid = 1'b0; w_last = 1'b0;
        @(negedge clk);
        // 2: single write
        txn(1'b1, 4'd5, 1, 1'b0, 4'd0, 8'd0, 0, 0, 0, -1);
        // 3: read burst len 3
        txn(1'b0, 4'd0, 1, 1'b1, 4'd3, 8'd3, 0, 0, 0, -1);
        // 4: backpressure, toggling r_ready
        txn(1'b0, 4'd0, 1, 1'b1, 4'd9, 8'd1, 1, 0, 0, -1);
        // 5: concurrent AW+AR, 8 W beats with gaps, delayed b_ready
        txn(1'b1, 4'd1, 8, 1'b1, 4'd2, 8'd5, 2, 40, 10, -1);
        // 6: longest burst
        txn(1'b0, 4'd0, 1, 1'b1, 4'd7, 8'd255, 0, 0, 0, -1);
        // random mixed traffic
        for (int i = 0; i < 25; i++) begin
            bit dw, dr;
            dw = $urandom_range(0, 1) == 1;
            dr = $urandom_range(0, 1) == 1;
            txn(dw, 4'($urandom), $urandom_range(1, 9), dr, 4'($urandom),
                8'($urandom_range(0, 20)), $urandom_range(0, 2), $urandom_range(0, 60),
                $urandom_range(0, 4), -1);
        end
        // reset mid-burst with a write also in flight
        txn(1'b1, 4'd6, 50, 1'b1, 4'd4, 8'd255, 0, 10, 0, 20);
        rst_ni = 1'b0;
        #1;
        chk("midrst_r_valid", r_valid, 0);
        chk("midrst_w_ready", w_ready, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_ar_ready", ar_ready, 1);
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", idle, 1);
        // fresh transaction after abandoned burst
        txn(1'b1, 4'd12, 2, 1'b1, 4'd13, 8'd2, 2, 20, 1, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
